// File: rtl/spram_access_ctrl.sv
// spram_access_ctrl: single-master front end for the 128 KiB byte-wide SPRAM
// bank wrapper. A boot-time stream loader fills the ROM image; a host port
// serves the emulator core afterwards. All memory-side signals are registered
// and the read address is held through the data-return cycle so the wrapper's
// combinational bank mux selects the right byte.
// Optional feature: define SPRAM_LOAD_CHECKSUM_EN to add the load_sum output.
module spram_access_ctrl #(
  parameter int MEM_BYTES = 131072,
  parameter int ADDR_W    = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [17:0]       load_len,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              load_busy,
  output logic              load_done,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [7:0]        host_wdata,
  output logic              host_ack,
  output logic              host_rvalid,
  output logic [7:0]        host_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  output logic              mem_wren,
  output logic              mem_cs,
  output logic              mem_standby,
  output logic              mem_sleep,
  output logic              mem_poweroff_n,
  input  logic [7:0]        mem_dout
`ifdef SPRAM_LOAD_CHECKSUM_EN
  ,
  output logic [7:0]        load_sum
`endif
);

  localparam logic [17:0] MEM_LEN = 18'(MEM_BYTES);

  typedef enum logic {
    IDLE,
    LOAD
  } state_t;

  state_t      state_q, state_d;
  logic [17:0] len_q, len_d;
  logic [17:0] ptr_q, ptr_d;
  logic        done_d;
  logic        clear_sum;
  logic        s_fire;
  logic        rd_p1, rd_p2;
  logic        rd_block;

  assign mem_standby    = 1'b0;
  assign mem_sleep      = 1'b0;
  assign mem_poweroff_n = 1'b1;

  // Handshakes: loader is served only in LOAD, host only in IDLE and never in
  // the cycle right after a read was accepted (that read's address must still
  // be on the port when its data is captured).
  always_comb begin
    s_ready   = (state_q == LOAD);
    load_busy = (state_q == LOAD);
    s_fire    = s_valid & s_ready;
    rd_block  = rd_p1;
    host_ack  = host_req & (state_q == IDLE) & ~rd_block;
  end

  // Next-state logic for the loader: latch the saturated length on start,
  // advance the write pointer per accepted byte, finish on the last one.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    ptr_d     = ptr_q;
    done_d    = 1'b0;
    clear_sum = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_start) begin
          clear_sum = 1'b1;
          if (load_len == 18'd0) begin
            done_d = 1'b1;
          end else begin
            state_d = LOAD;
            len_d   = (load_len > MEM_LEN) ? MEM_LEN : load_len;
            ptr_d   = 18'd0;
          end
        end
      end
      LOAD: begin
        if (s_valid) begin
          ptr_d = ptr_q + 18'd1;
          if (ptr_q == len_q - 18'd1) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Loader state register; load_done lines up with the final write on the port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      len_q     <= 18'd0;
      ptr_q     <= 18'd0;
      load_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      ptr_q     <= ptr_d;
      load_done <= done_d;
    end
  end

  // Registered memory port; address and data hold whenever chip select is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_cs   <= 1'b0;
      mem_wren <= 1'b0;
      mem_addr <= '0;
      mem_din  <= 8'd0;
    end else begin
      mem_cs   <= s_fire | host_ack;
      mem_wren <= s_fire | (host_ack & host_we);
      if (s_fire) begin
        mem_addr <= ptr_q[ADDR_W-1:0];
        mem_din  <= s_data;
      end else if (host_ack) begin
        mem_addr <= host_addr;
        if (host_we) begin
          mem_din <= host_wdata;
        end
      end
    end
  end

  // Read return pipeline: issue, capture dout while the address is held, strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_p1       <= 1'b0;
      rd_p2       <= 1'b0;
      host_rvalid <= 1'b0;
      host_rdata  <= 8'd0;
    end else begin
      rd_p1       <= host_ack & ~host_we;
      rd_p2       <= rd_p1;
      host_rvalid <= rd_p2;
      if (rd_p2) begin
        host_rdata <= mem_dout;
      end
    end
  end

`ifdef SPRAM_LOAD_CHECKSUM_EN
  // Wrapping byte sum of the loaded image, cleared whenever a load is started.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_sum <= 8'd0;
    end else if (clear_sum) begin
      load_sum <= 8'd0;
    end else if (s_fire) begin
      load_sum <= load_sum + s_data;
    end
  end
`else
  logic unused_clear_sum;
  assign unused_clear_sum = clear_sum;
`endif

endmodule
